// File: rtl/hazard_fwd_unit_pkg.sv
// Shared encodings for the hazard/forwarding controller: forward selects,
// result sources, Tuse classes, and the per-stage Tnew rule.
package hazard_fwd_unit_pkg;

    typedef enum logic [2:0] {
        FWD_REG   = 3'd0,
        FWD_AO_M  = 3'd1,
        FWD_AO_W  = 3'd2,
        FWD_PC8_M = 3'd3,
        FWD_PC8_W = 3'd4,
        FWD_DM_W  = 3'd5
    } fwd_sel_e;

    typedef enum logic [1:0] {
        SRC_NONE = 2'd0,
        SRC_ALU  = 2'd1,
        SRC_DM   = 2'd2,
        SRC_PC8  = 2'd3
    } src_e;

    typedef enum logic [1:0] {
        TUSE_D     = 2'd0,
        TUSE_E     = 2'd1,
        TUSE_M     = 2'd2,
        TUSE_NEVER = 2'd3
    } tuse_e;

    typedef enum logic [1:0] {
        STAGE_E = 2'd0,
        STAGE_M = 2'd1,
        STAGE_W = 2'd2
    } stage_e;

    // Cycles until a producer sitting in the given stage has its result on a forward path.
    function automatic logic [1:0] tnew(input stage_e stage, input src_e src);
        logic [1:0] t;
        t = 2'd0;
        case (stage)
            STAGE_E: begin
                if (src == SRC_ALU)
                    t = 2'd1;
                else if (src == SRC_DM)
                    t = 2'd2;
            end
            STAGE_M: begin
                if (src == SRC_DM)
                    t = 2'd1;
            end
            STAGE_W: t = 2'd0;
            default: t = 2'd0;
        endcase
        return t;
    endfunction

endpackage

// File: rtl/hazard_fwd_unit_fwd_pick.sv
// One forward-select picker: nearest-first (M over W) among slots whose result is ready.
// Callers disable a slot by tying its valid input low.
module hazard_fwd_unit_fwd_pick
    import hazard_fwd_unit_pkg::*;
#(
    parameter int REG_AW = 5
) (
    input  logic [REG_AW-1:0] op_i,
    input  logic              m_valid_i,
    input  logic [REG_AW-1:0] m_dst_i,
    input  src_e              m_src_i,
    input  logic              w_valid_i,
    input  logic [REG_AW-1:0] w_dst_i,
    input  src_e              w_src_i,
    output logic [2:0]        sel_o
);

    logic m_hit;
    logic w_hit;

    assign m_hit = m_valid_i && (m_dst_i != '0) && (m_dst_i == op_i) && (m_src_i != SRC_NONE);
    assign w_hit = w_valid_i && (w_dst_i != '0) && (w_dst_i == op_i) && (w_src_i != SRC_NONE);

    // A load still in M is not ready; it falls through to W (the stall keeps that case unreachable).
    always_comb begin
        sel_o = FWD_REG;
        if (m_hit && (m_src_i == SRC_ALU)) begin
            sel_o = FWD_AO_M;
        end else if (m_hit && (m_src_i == SRC_PC8)) begin
            sel_o = FWD_PC8_M;
        end else if (w_hit) begin
            case (w_src_i)
                SRC_ALU: sel_o = FWD_AO_W;
                SRC_PC8: sel_o = FWD_PC8_W;
                SRC_DM:  sel_o = FWD_DM_W;
                default: sel_o = FWD_REG;
            endcase
        end
    end

endmodule

// File: rtl/hazard_fwd_unit.sv
// Stall/forward controller for the 5-stage pipeline: shadow E/M/W write descriptors plus Tuse/Tnew checks.
// Optional macro HAZARD_DFWD_W_EN: D-stage compare selects also take W-slot results.
module hazard_fwd_unit
    import hazard_fwd_unit_pkg::*;
#(
    parameter int REG_AW = 5,
    parameter int SEL_W  = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [REG_AW-1:0] d_rs,
    input  logic [REG_AW-1:0] d_rt,
    input  logic [1:0]        d_tuse_rs,
    input  logic [1:0]        d_tuse_rt,
    input  logic [REG_AW-1:0] d_dst,
    input  logic [1:0]        d_src,
    output logic              stall,
    output logic [SEL_W-1:0]  rs_Dforward,
    output logic [SEL_W-1:0]  rt_Dforward,
    output logic [SEL_W-1:0]  rs_Eforward,
    output logic [SEL_W-1:0]  rt_Eforward,
    output logic [SEL_W-1:0]  rt_Mforward
);

`ifdef HAZARD_DFWD_W_EN
    localparam logic D_USE_W = 1'b1;
`else
    localparam logic D_USE_W = 1'b0;
`endif

    localparam int N_PICK = 5;
    localparam int P_RS_D = 0;
    localparam int P_RT_D = 1;
    localparam int P_RS_E = 2;
    localparam int P_RT_E = 3;
    localparam int P_RT_M = 4;

    logic              e_valid_q, e_valid_d;
    logic [REG_AW-1:0] e_dst_q, e_dst_d;
    src_e              e_src_q, e_src_d;
    logic [REG_AW-1:0] e_rs_q, e_rs_d;
    logic [REG_AW-1:0] e_rt_q, e_rt_d;

    logic              m_valid_q, m_valid_d;
    logic [REG_AW-1:0] m_dst_q, m_dst_d;
    src_e              m_src_q, m_src_d;
    logic [REG_AW-1:0] m_rt_q, m_rt_d;

    logic              w_valid_q, w_valid_d;
    logic [REG_AW-1:0] w_dst_q, w_dst_d;
    src_e              w_src_q, w_src_d;

    function automatic logic slot_hit(input logic valid, input logic [REG_AW-1:0] dst,
                                      input src_e src, input logic [REG_AW-1:0] op);
        return valid && (dst != '0) && (dst == op) && (src != SRC_NONE);
    endfunction

    logic [1:0] e_tnew;
    logic [1:0] m_tnew;
    logic       stall_rs;
    logic       stall_rt;
    logic       stall_raw;

    assign e_tnew = tnew(STAGE_E, e_src_q);
    assign m_tnew = tnew(STAGE_M, m_src_q);

    // W is excluded: its value reaches D through register-file write-through or the W forward path.
    assign stall_rs = (d_tuse_rs != TUSE_NEVER) &&
                      ((slot_hit(e_valid_q, e_dst_q, e_src_q, d_rs) && (e_tnew > d_tuse_rs)) ||
                       (slot_hit(m_valid_q, m_dst_q, m_src_q, d_rs) && (m_tnew > d_tuse_rs)));
    assign stall_rt = (d_tuse_rt != TUSE_NEVER) &&
                      ((slot_hit(e_valid_q, e_dst_q, e_src_q, d_rt) && (e_tnew > d_tuse_rt)) ||
                       (slot_hit(m_valid_q, m_dst_q, m_src_q, d_rt) && (m_tnew > d_tuse_rt)));
    assign stall_raw = stall_rs || stall_rt;

    always_comb begin
        e_valid_d = 1'b1;
        e_dst_d   = d_dst;
        e_src_d   = src_e'(d_src);
        e_rs_d    = d_rs;
        e_rt_d    = d_rt;
        if (stall_raw) begin
            e_valid_d = 1'b0;
            e_dst_d   = '0;
            e_src_d   = SRC_NONE;
            e_rs_d    = '0;
            e_rt_d    = '0;
        end
        m_valid_d = e_valid_q;
        m_dst_d   = e_dst_q;
        m_src_d   = e_src_q;
        m_rt_d    = e_rt_q;
        w_valid_d = m_valid_q;
        w_dst_d   = m_dst_q;
        w_src_d   = m_src_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            e_valid_q <= 1'b0;
            e_dst_q   <= '0;
            e_src_q   <= SRC_NONE;
            e_rs_q    <= '0;
            e_rt_q    <= '0;
            m_valid_q <= 1'b0;
            m_dst_q   <= '0;
            m_src_q   <= SRC_NONE;
            m_rt_q    <= '0;
            w_valid_q <= 1'b0;
            w_dst_q   <= '0;
            w_src_q   <= SRC_NONE;
        end else begin
            e_valid_q <= e_valid_d;
            e_dst_q   <= e_dst_d;
            e_src_q   <= e_src_d;
            e_rs_q    <= e_rs_d;
            e_rt_q    <= e_rt_d;
            m_valid_q <= m_valid_d;
            m_dst_q   <= m_dst_d;
            m_src_q   <= m_src_d;
            m_rt_q    <= m_rt_d;
            w_valid_q <= w_valid_d;
            w_dst_q   <= w_dst_d;
            w_src_q   <= w_src_d;
        end
    end

    logic [REG_AW-1:0] pick_op    [N_PICK];
    logic              pick_m_en  [N_PICK];
    logic              pick_w_en  [N_PICK];
    logic [2:0]        pick_sel   [N_PICK];

    assign pick_op[P_RS_D]   = d_rs;
    assign pick_op[P_RT_D]   = d_rt;
    assign pick_op[P_RS_E]   = e_rs_q;
    assign pick_op[P_RT_E]   = e_rt_q;
    assign pick_op[P_RT_M]   = m_rt_q;

    // Store data in M can only be fed from W; the slot in M is the store itself.
    assign pick_m_en[P_RS_D] = m_valid_q;
    assign pick_m_en[P_RT_D] = m_valid_q;
    assign pick_m_en[P_RS_E] = m_valid_q;
    assign pick_m_en[P_RT_E] = m_valid_q;
    assign pick_m_en[P_RT_M] = 1'b0;

    assign pick_w_en[P_RS_D] = w_valid_q & D_USE_W;
    assign pick_w_en[P_RT_D] = w_valid_q & D_USE_W;
    assign pick_w_en[P_RS_E] = w_valid_q;
    assign pick_w_en[P_RT_E] = w_valid_q;
    assign pick_w_en[P_RT_M] = w_valid_q;

    for (genvar gi = 0; gi < N_PICK; gi++) begin : g_pick
        hazard_fwd_unit_fwd_pick #(
            .REG_AW (REG_AW)
        ) u_pick (
            .op_i      (pick_op[gi]),
            .m_valid_i (pick_m_en[gi]),
            .m_dst_i   (m_dst_q),
            .m_src_i   (m_src_q),
            .w_valid_i (pick_w_en[gi]),
            .w_dst_i   (w_dst_q),
            .w_src_i   (w_src_q),
            .sel_o     (pick_sel[gi])
        );
    end

    assign stall       = stall_raw & ~reset;
    assign rs_Dforward = reset ? '0 : SEL_W'(pick_sel[P_RS_D]);
    assign rt_Dforward = reset ? '0 : SEL_W'(pick_sel[P_RT_D]);
    assign rs_Eforward = reset ? '0 : SEL_W'(pick_sel[P_RS_E]);
    assign rt_Eforward = reset ? '0 : SEL_W'(pick_sel[P_RT_E]);
    assign rt_Mforward = reset ? '0 : SEL_W'(pick_sel[P_RT_M]);

endmodule
